// File: rtl/junction_turn_sequencer_pkg.sv
// Shared encodings for the junction turn sequencer: tone directions, motor/speed codes, FSM states.
package junction_turn_sequencer_pkg;

  typedef enum logic [2:0] {
    DIR_STRAIGHT = 3'd0,
    DIR_LEFT     = 3'd1,
    DIR_RIGHT    = 3'd2,
    DIR_BACK     = 3'd3,
    DIR_STOP     = 3'd4
  } td_dir_e;

  localparam logic [1:0] MOT_BRAKE = 2'b00;
  localparam logic [1:0] MOT_FWD   = 2'b01;
  localparam logic [1:0] MOT_REV   = 2'b10;

  localparam logic [1:0] SPD_OFF    = 2'd0;
  localparam logic [1:0] SPD_VEER   = 2'd1;
  localparam logic [1:0] SPD_FULL   = 2'd2;
  localparam logic [1:0] SPD_NINETY = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STOPPED,
    ST_ROLL,
    ST_TURN,
    ST_EXIT,
    ST_HALT,
    ST_FAULT
  } state_e;

  // Codes 4..7 all mean "stay put"; only 0..3 describe a manoeuvre.
  function automatic logic is_move_dir(input logic [2:0] dir);
    return dir < 3'd4;
  endfunction

endpackage

// File: rtl/junction_turn_sequencer_shaft_pulse_counter.sv
// Per-wheel encoder front end: 2-flop synchroniser, rising-edge detect and a saturating
// edge counter that can be cleared (loading the same-cycle edge) or frozen.
module shaft_pulse_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shaft_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [2:0]       sync_q;
  logic             edge_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign edge_w = sync_q[1] & ~sync_q[2];

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {{(CNT_W-1){1'b0}}, edge_w};
    end else if (en_i && edge_w && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], shaft_i};
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/junction_turn_sequencer.sv
// Junction handling FSM: stop, wait for a tone, roll to centre, turn by shaft counts,
// exit the junction, then hand the motors back to the drive state machine.
module junction_turn_sequencer
  import junction_turn_sequencer_pkg::*;
#(
  parameter int unsigned ROLL_PULSES    = 12,
  parameter int unsigned TURN90_PULSES  = 20,
  parameter int unsigned TURN180_PULSES = 40,
  parameter int unsigned TONE_TO_CYC    = 100_000_000,
  parameter int unsigned STEP_TO_CYC    = 150_000_000,
  parameter int          CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       junction_det,
  input  logic       col_clear,
  input  logic       td_valid,
  input  logic [2:0] td_dir,
  input  logic       shaft_l,
  input  logic       shaft_r,
  output logic       seq_active,
  output logic [1:0] mot_l,
  output logic [1:0] mot_r,
  output logic [1:0] spd_sel,
  output logic       seq_done,
  output logic       seq_fault
);

  localparam int unsigned TMR_MAX = (TONE_TO_CYC > STEP_TO_CYC) ? TONE_TO_CYC : STEP_TO_CYC;
  localparam int          TMR_W   = $clog2(TMR_MAX + 1);

  state_e           state_q, state_d;
  td_dir_e          dir_q, dir_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_l, cnt_r;
  logic [CNT_W-1:0] target_w;
  logic             active_w, frozen_w, entry_w, step_met_w, step_to_w, tone_to_w;

  assign active_w = (state_q != ST_IDLE);
  assign frozen_w = active_w && !col_clear;
  assign entry_w  = (state_d != state_q);

  shaft_pulse_counter #(.CNT_W(CNT_W)) u_cnt_l (
    .clk(clk), .rst_n(rst_n), .shaft_i(shaft_l), .clr_i(entry_w), .en_i(!frozen_w), .cnt_o(cnt_l)
  );
  shaft_pulse_counter #(.CNT_W(CNT_W)) u_cnt_r (
    .clk(clk), .rst_n(rst_n), .shaft_i(shaft_r), .clr_i(entry_w), .en_i(!frozen_w), .cnt_o(cnt_r)
  );

  always_comb begin
    target_w = CNT_W'(ROLL_PULSES);
    if (state_q == ST_TURN) begin
      target_w = (dir_q == DIR_BACK) ? CNT_W'(TURN180_PULSES) : CNT_W'(TURN90_PULSES);
    end
  end

  assign step_met_w = (cnt_l >= target_w) && (cnt_r >= target_w);
  assign step_to_w  = (timer_q == TMR_W'(STEP_TO_CYC - 1));
  assign tone_to_w  = (timer_q == TMR_W'(TONE_TO_CYC - 1));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (!frozen_w) begin
      unique case (state_q)
        ST_IDLE: if (junction_det) state_d = ST_STOPPED;
        ST_STOPPED: begin
          if (td_valid) begin
            if (is_move_dir(td_dir)) begin
              dir_d   = td_dir_e'(td_dir);
              state_d = ST_ROLL;
            end else begin
              state_d = ST_HALT;
            end
          end else if (tone_to_w) begin
            state_d = ST_FAULT;
          end
        end
        ST_ROLL: begin
          if (step_met_w)     state_d = (dir_q == DIR_STRAIGHT) ? ST_EXIT : ST_TURN;
          else if (step_to_w) state_d = ST_FAULT;
        end
        ST_TURN: begin
          if (step_met_w)     state_d = ST_EXIT;
          else if (step_to_w) state_d = ST_FAULT;
        end
        ST_EXIT: begin
          if (!junction_det) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (step_to_w) begin
            state_d = ST_FAULT;
          end
        end
        ST_HALT: begin
          if (td_valid && is_move_dir(td_dir)) begin
            dir_d   = td_dir_e'(td_dir);
            state_d = ST_ROLL;
          end
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  // Timer only runs in states that can time out; any state change restarts it.
  always_comb begin
    timer_d = timer_q;
    if (entry_w) begin
      timer_d = '0;
    end else if (!frozen_w && (state_q inside {ST_STOPPED, ST_ROLL, ST_TURN, ST_EXIT})) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_STRAIGHT;
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    mot_l   = MOT_BRAKE;
    mot_r   = MOT_BRAKE;
    spd_sel = SPD_OFF;
    if (!frozen_w) begin
      unique case (state_q)
        ST_ROLL, ST_EXIT: begin
          mot_l   = MOT_FWD;
          mot_r   = MOT_FWD;
          spd_sel = SPD_FULL;
        end
        ST_TURN: begin
          mot_l   = (dir_q == DIR_LEFT) ? MOT_REV : MOT_FWD;
          mot_r   = (dir_q == DIR_LEFT) ? MOT_FWD : MOT_REV;
          spd_sel = SPD_NINETY;
        end
        default: ;
      endcase
    end
  end

  assign seq_active = active_w;
  assign seq_done   = done_q;
  assign seq_fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_junction_turn_sequencer.sv
// Directed bench for junction_turn_sequencer using small pulse/timeout parameters.
module tb_junction_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, junction_det, col_clear, td_valid, shaft_l, shaft_r;
  logic [2:0] td_dir;
  logic       seq_active, seq_done, seq_fault;
  logic [1:0] mot_l, mot_r, spd_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  junction_turn_sequencer #(
    .ROLL_PULSES(3), .TURN90_PULSES(4), .TURN180_PULSES(8),
    .TONE_TO_CYC(200), .STEP_TO_CYC(300), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .junction_det(junction_det), .col_clear(col_clear),
    .td_valid(td_valid), .td_dir(td_dir), .shaft_l(shaft_l), .shaft_r(shaft_r),
    .seq_active(seq_active), .mot_l(mot_l), .mot_r(mot_r), .spd_sel(spd_sel),
    .seq_done(seq_done), .seq_fault(seq_fault)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tone(input int dir);
    td_valid = 1'b1;
    td_dir   = 3'(dir);
    cyc(1);
    td_valid = 1'b0;
  endtask

  task automatic pulses(input int nl, input int nr);
    for (int i = 0; i < ((nl > nr) ? nl : nr); i++) begin
      shaft_l = (i < nl);
      shaft_r = (i < nr);
      cyc(3);
      shaft_l = 1'b0;
      shaft_r = 1'b0;
      cyc(3);
    end
  endtask

  // Compact output snapshot check: active, left, right, speed.
  task automatic check_out(input string tag, input int act, input int ml, input int mr, input int sp);
    check_eq({tag, ".active"}, int'(seq_active), act);
    check_eq({tag, ".mot_l"},  int'(mot_l), ml);
    check_eq({tag, ".mot_r"},  int'(mot_r), mr);
    check_eq({tag, ".spd"},    int'(spd_sel), sp);
  endtask

  initial begin
    rst_n = 1'b0; junction_det = 1'b0; col_clear = 1'b1; td_valid = 1'b0;
    td_dir = 3'd0; shaft_l = 1'b0; shaft_r = 1'b0;
    cyc(2);
    check_out("reset", 0, 0, 0, 0);
    check_eq("reset.done", int'(seq_done), 0);
    check_eq("reset.fault", int'(seq_fault), 0);
    rst_n = 1'b1;
    cyc(1);

    // LEFT turn through the full sequence
    junction_det = 1'b1; cyc(1);
    check_out("left.stopped", 1, 0, 0, 0);
    tone(1);
    check_out("left.roll", 1, 1, 1, 2);
    pulses(2, 2);
    check_out("left.roll2", 1, 1, 1, 2);
    pulses(1, 1);
    check_out("left.turn", 1, 2, 1, 3);
    pulses(4, 4);
    check_out("left.exit", 1, 1, 1, 2);
    junction_det = 1'b0; cyc(1);
    check_eq("left.done", int'(seq_done), 1);
    check_eq("left.idle", int'(seq_active), 0);
    cyc(1);
    check_eq("left.done_clr", int'(seq_done), 0);

    // BACK: 180-degree spin needs 8 edges on both wheels
    junction_det = 1'b1; cyc(1);
    tone(3);
    pulses(3, 3);
    check_out("back.turn", 1, 1, 2, 3);
    pulses(7, 7);
    check_out("back.turn7", 1, 1, 2, 3);
    pulses(1, 0);
    check_out("back.turn8_7", 1, 1, 2, 3);
    pulses(0, 1);
    check_out("back.exit", 1, 1, 1, 2);
    junction_det = 1'b0; cyc(1);
    check_eq("back.done", int'(seq_done), 1);

    // STOP -> HALT, no timeout; then RIGHT with a collision freeze mid-TURN
    junction_det = 1'b1; cyc(2);
    tone(4);
    check_out("halt", 1, 0, 0, 0);
    cyc(1000);
    check_eq("halt.no_fault", int'(seq_fault), 0);
    check_out("halt.1000", 1, 0, 0, 0);
    tone(2);
    check_out("right.roll", 1, 1, 1, 2);
    pulses(3, 3);
    check_out("right.turn", 1, 1, 2, 3);
    pulses(2, 2);
    col_clear = 1'b0; cyc(1);
    check_out("col.brake", 1, 0, 0, 0);
    pulses(3, 3);
    cyc(31);
    check_out("col.still", 1, 0, 0, 0);
    col_clear = 1'b1; cyc(1);
    check_out("col.resume", 1, 1, 2, 3);
    pulses(1, 1);
    check_out("col.count3", 1, 1, 2, 3);
    pulses(1, 1);
    check_out("col.exit", 1, 1, 1, 2);
    junction_det = 1'b0; cyc(1);
    check_eq("right.done", int'(seq_done), 1);
    cyc(1);

    // Tone timeout -> sticky fault
    junction_det = 1'b1; cyc(150);
    check_eq("tone.pre_fault", int'(seq_fault), 0);
    cyc(60);
    check_eq("tone.fault", int'(seq_fault), 1);
    check_out("tone.fault_out", 1, 0, 0, 0);
    tone(1);
    junction_det = 1'b0; cyc(5);
    check_eq("tone.sticky", int'(seq_fault), 1);
    check_out("tone.sticky_out", 1, 0, 0, 0);
    rst_n = 1'b0; cyc(1);
    check_eq("tone.rst_clr", int'(seq_fault), 0);
    rst_n = 1'b1; cyc(1);

    // Tone coinciding with junction_det in IDLE is ignored
    junction_det = 1'b1; td_valid = 1'b1; td_dir = 3'd1; cyc(1);
    td_valid = 1'b0;
    check_out("idle_tone.stopped", 1, 0, 0, 0);
    cyc(2);
    check_out("idle_tone.still", 1, 0, 0, 0);

    // Async reset mid-ROLL
    tone(0);
    check_out("rst.roll", 1, 1, 1, 2);
    #2 rst_n = 1'b0;
    #1 check_out("rst.async", 0, 0, 0, 0);
    cyc(1);
    rst_n = 1'b1; cyc(1);
    check_out("rst.stopped", 1, 0, 0, 0);
    tone(6);
    cyc(250);
    check_eq("dir6.no_fault", int'(seq_fault), 0);
    check_out("dir6.halt", 1, 0, 0, 0);
    tone(1);
    check_out("dir6.roll", 1, 1, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
